// File: rtl/memory2_load_return_if.sv
// Bundle for the second memory stage: pipeline/BRAM inputs and write-back outputs.
// The stage itself uses the slave modport; the driving side uses master.
interface memory2_load_return_if;
    logic        memory2_used;
    logic [63:0] inst;
    logic [63:0] doutb;
    logic [63:0] alu_result;
    logic        memory2_stall;
    logic        flush;
    logic        writeback_used;
    logic [63:0] inst_to_the_next;
    logic [63:0] wb_data;
    logic [1:0]  wb_we;
    logic [9:0]  wb_rd;

    modport master (
        output memory2_used, inst, doutb, alu_result, memory2_stall, flush,
        input  writeback_used, inst_to_the_next, wb_data, wb_we, wb_rd
    );

    modport slave (
        input  memory2_used, inst, doutb, alu_result, memory2_stall, flush,
        output writeback_used, inst_to_the_next, wb_data, wb_we, wb_rd
    );
endinterface

// File: rtl/memory2_load_return.sv
// Second memory stage: aligns BRAM read data with its instruction pair and builds
// per-lane write-back data/enables, holding the read word across downstream stalls.
module memory2_load_return #(
    parameter logic [5:0]  OP_LOAD    = 6'h23,
    parameter logic [63:0] OP_WB_MASK = 64'h0
) (
    input logic                 clk,
    input logic                 rstn,
    memory2_load_return_if.slave bus
);

    typedef enum logic [0:0] {StPass, StHold} state_e;

    state_e      state_q;
    logic [63:0] hold_data_q;
    logic        writeback_used_q;
    logic [63:0] inst_to_the_next_q;
    logic [63:0] wb_data_q;
    logic [1:0]  wb_we_q;
    logic [9:0]  wb_rd_q;

    logic [63:0] src_data;
    logic [63:0] wb_data_d;
    logic [1:0]  wb_we_d;
    logic [9:0]  wb_rd_d;
    logic        valid_d;
    logic        update;

    assign valid_d = bus.memory2_used & ~bus.flush;
    assign update  = ~bus.memory2_stall | bus.flush;
    assign wb_rd_d = {bus.inst[57:53], bus.inst[25:21]};

    // BRAM data is only valid the cycle after its address, so HOLD replays the capture.
    assign src_data = (state_q == StHold) ? hold_data_q : bus.doutb;

    always_comb begin
        logic [5:0] op;
        logic [4:0] rd;
        logic       is_load;
        wb_data_d = '0;
        wb_we_d   = '0;
        op        = '0;
        rd        = '0;
        is_load   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            op      = bus.inst[32*k+26 +: 6];
            rd      = bus.inst[32*k+21 +: 5];
            is_load = (op == OP_LOAD);
            wb_data_d[32*k +: 32] = is_load ? src_data[32*k +: 32]
                                            : bus.alu_result[32*k +: 32];
            wb_we_d[k] = (is_load | OP_WB_MASK[op]) & (rd != 5'd0) & valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q            <= StPass;
            hold_data_q        <= '0;
            writeback_used_q   <= 1'b0;
            inst_to_the_next_q <= '0;
            wb_data_q          <= '0;
            wb_we_q            <= '0;
            wb_rd_q            <= '0;
        end else begin
            if (bus.flush) begin
                state_q     <= StPass;
                hold_data_q <= '0;
            end else if (state_q == StPass) begin
                if (bus.memory2_used && bus.memory2_stall) begin
                    hold_data_q <= bus.doutb;
                    state_q     <= StHold;
                end
            end else if (!bus.memory2_stall) begin
                state_q <= StPass;
            end

            if (update) begin
                writeback_used_q   <= valid_d;
                inst_to_the_next_q <= bus.inst;
                wb_data_q          <= wb_data_d;
                wb_we_q            <= wb_we_d;
                wb_rd_q            <= wb_rd_d;
            end
        end
    end

    assign bus.writeback_used   = writeback_used_q;
    assign bus.inst_to_the_next = inst_to_the_next_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_we            = wb_we_q;
    assign bus.wb_rd            = wb_rd_q;

endmodule

// File: tb/tb_memory2_load_return.sv
// Directed bench for memory2_load_return: load/ALU mixes, stalls, flush, bubbles, resets.
module tb_memory2_load_return;

    localparam logic [5:0] OpLd  = 6'h23;
    localparam logic [5:0] OpAlu = 6'h08;
    localparam logic [5:0] OpNop = 6'h10;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    memory2_load_return_if bus ();

    memory2_load_return #(
        .OP_LOAD    (6'h23),
        .OP_WB_MASK (64'h0000_0000_0000_0100)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input logic [5:0] op, input logic [4:0] rd);
        return {op, rd, 21'h0A5C3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic used, input logic [63:0] data,
                           input logic [1:0] we, input logic [9:0] rd);
        chk({tag, ".used"}, 64'(bus.writeback_used), 64'(used));
        chk({tag, ".data"}, bus.wb_data, data);
        chk({tag, ".we"}, 64'(bus.wb_we), 64'(we));
        chk({tag, ".rd"}, 64'(bus.wb_rd), 64'(rd));
    endtask

    task automatic drive(input logic used, input logic [63:0] inst, input logic [63:0] dout,
                         input logic [63:0] alu, input logic stall, input logic fl);
        bus.memory2_used  = used;
        bus.inst          = inst;
        bus.doutb         = dout;
        bus.alu_result    = alu;
        bus.memory2_stall = stall;
        bus.flush         = fl;
    endtask

    initial begin
        logic [63:0] i_a, i_b, i_c, i_d, i_e, i_f, i_g;
        i_a = {lane(OpAlu, 5'd4), lane(OpLd, 5'd3)};
        i_b = {lane(OpLd, 5'd7), lane(OpAlu, 5'd2)};
        i_c = {lane(OpAlu, 5'd1), lane(OpLd, 5'd5)};
        i_d = {lane(OpAlu, 5'd6), lane(OpLd, 5'd0)};
        i_e = {lane(OpNop, 5'd6), lane(OpLd, 5'd9)};
        i_f = {lane(OpNop, 5'd0), lane(OpLd, 5'd3)};
        i_g = {lane(OpLd, 5'd8), lane(OpLd, 5'd2)};

        // Reset with random inputs
        rstn = 1'b0;
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 1'($urandom));
        tick();
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              1'b1, 1'b0);
        tick();
        chk_out("reset", 1'b0, 64'h0, 2'b00, 10'h0);
        chk("reset.inst", bus.inst_to_the_next, 64'h0);

        // Load lane 0, ALU lane 1
        rstn = 1'b1;
        drive(1'b1, i_a, 64'hAAAA_BBBB_1111_2222, 64'h0000_0005_1234_5678, 1'b0, 1'b0);
        tick();
        chk_out("mix", 1'b1, 64'h0000_0005_1111_2222, 2'b11, {5'd4, 5'd3});
        chk("mix.inst", bus.inst_to_the_next, i_a);

        // Stall three cycles across a lane-1 load; doutb turns to junk after cycle one
        drive(1'b1, i_b, 64'hDEAD_BEEF_0000_0000, 64'h1111_1111_0000_0042, 1'b1, 1'b0);
        tick();
        chk_out("stall1", 1'b1, 64'h0000_0005_1111_2222, 2'b11, {5'd4, 5'd3});
        bus.doutb = 64'h0123_4567_89AB_CDEF;
        tick();
        chk_out("stall2", 1'b1, 64'h0000_0005_1111_2222, 2'b11, {5'd4, 5'd3});
        tick();
        chk("stall3.data", bus.wb_data, 64'h0000_0005_1111_2222);
        bus.memory2_stall = 1'b0;
        tick();
        chk_out("release", 1'b1, 64'hDEAD_BEEF_0000_0042, 2'b11, {5'd7, 5'd2});
        chk("release.inst", bus.inst_to_the_next, i_b);

        // Bubble
        drive(1'b0, i_a, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0);
        tick();
        chk("bubble.used", 64'(bus.writeback_used), 64'h0);
        chk("bubble.we", 64'(bus.wb_we), 64'h0);

        // Flush while holding
        drive(1'b1, i_c, 64'h0000_0000_5555_6666, 64'h0000_0003_0000_0000, 1'b1, 1'b0);
        tick();
        bus.doutb = 64'h9999_9999_9999_9999;
        tick();
        bus.flush = 1'b1;
        tick();
        chk("flush.used", 64'(bus.writeback_used), 64'h0);
        chk("flush.we", 64'(bus.wb_we), 64'h0);
        drive(1'b1, i_c, 64'h0000_0000_7777_8888, 64'h0000_0009_0000_0000, 1'b0, 1'b0);
        tick();
        chk_out("postflush", 1'b1, 64'h0000_0009_7777_8888, 2'b11, {5'd1, 5'd5});

        // Load with rd=0, then a lane whose opcode does not write back
        drive(1'b1, i_d, 64'h0000_0000_1234_0000, 64'h0000_0077_0000_0000, 1'b0, 1'b0);
        tick();
        chk_out("rd0", 1'b1, 64'h0000_0077_1234_0000, 2'b10, {5'd6, 5'd0});
        drive(1'b1, i_e, 64'h0000_0000_4321_0000, 64'h0000_0088_0000_0000, 1'b0, 1'b0);
        tick();
        chk_out("nowb", 1'b1, 64'h0000_0088_4321_0000, 2'b01, {5'd6, 5'd9});

        // Both lanes load from the same word, no extra latency
        drive(1'b1, i_g, 64'h1357_9BDF_2468_ACE0, 64'h0, 1'b0, 1'b0);
        tick();
        chk_out("dual", 1'b1, 64'h1357_9BDF_2468_ACE0, 2'b11, {5'd8, 5'd2});

        // Reset while holding
        drive(1'b1, i_f, 64'h0000_0000_BAD0_BAD0, 64'h0, 1'b1, 1'b0);
        tick();
        rstn = 1'b0;
        tick();
        chk_out("rsthold", 1'b0, 64'h0, 2'b00, 10'h0);
        chk("rsthold.inst", bus.inst_to_the_next, 64'h0);
        rstn = 1'b1;
        drive(1'b1, i_f, 64'h0000_0000_600D_600D, 64'h0, 1'b0, 1'b0);
        tick();
        chk_out("postrst", 1'b1, 64'h0000_0000_600D_600D, 2'b01, {5'd0, 5'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory2_load_return.md
# memory2_load_return

Second memory stage of the two-lane (2×32-bit) pipeline, the read-side counterpart of the stage that issues data-BRAM accesses. It consumes the 64-bit BRAM read word (`doutb`) one cycle after the address was launched, aligns it with the instruction it belongs to, and produces per-lane write-back data and enables. A one-entry hold register preserves the BRAM read data across downstream stalls, because the BRAM output is valid only in the cycle after its address.

## Interface
Parameters:
- `OP_LOAD`, 6'h23: lane opcode value that marks a load.
- `OP_WB_MASK`, 64'h0: bit *n* set means opcode *n* writes `rd` with the ALU result that arrives on `alu_result`.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rstn`  in  1  synchronous active-low reset, sampled on `posedge clk`.
- `memory2_used`  in  1  a valid instruction is present this cycle.
- `inst`  in  64  instruction pair. Lane k = `inst[32k+31:32k]`, opcode = bits [31:26], rd = bits [25:21].
- `doutb`  in  64  BRAM port-B read data. Lane k = `doutb[32k+31:32k]`. Valid only in the first cycle `memory2_used` is high for an instruction.
- `alu_result`  in  64  per-lane non-load results, carried alongside `inst`.
- `memory2_stall`  in  1  downstream cannot accept; hold outputs.
- `flush`  in  1  kill the instruction in this stage.
- `writeback_used`  out  1  write-back stage holds a valid instruction.
- `inst_to_the_next`  out  64  instruction forwarded to write-back.
- `wb_data`  out  64  per-lane write-back data.
- `wb_we`  out  2  per-lane register-write enable.
- `wb_rd`  out  10  `{rd1, rd0}`.

## Operation
- Lane k is a load iff opcode == `OP_LOAD`. Its data is `doutb` lane k, or `hold_data` lane k in HOLD.
- Lane k non-load data is `alu_result` lane k. `wb_we[k]` = load OR `OP_WB_MASK[opcode]`, gated by valid. rd = 0 forces `wb_we[k]` = 0.
- FSM, 2 states, reset to PASS:
  - PASS, `memory2_used` & `memory2_stall` & ~`flush`: `hold_data <= doutb`, go to HOLD.
  - PASS, no stall: outputs take `doutb` directly.
  - HOLD: `doutb` is ignored. On ~`memory2_stall`, outputs take `hold_data` and the FSM returns to PASS.
  - `flush` in any state: return to PASS and discard `hold_data`.
- Output register update, when ~`memory2_stall` or `flush`:
  - `writeback_used <= memory2_used & ~flush`.
  - `inst_to_the_next <= inst`.
  - `wb_data`, `wb_we`, `wb_rd` are computed as above. `wb_we` is forced to 0 when the new `writeback_used` is 0.
- `memory2_stall` & ~`flush`: all outputs hold their values.
- Upstream holds `inst`, `memory2_used` and `alu_result` stable while `memory2_stall` = 1. This block does not re-check them.

## Timing
- Reset, `rstn` = 0 at a clock edge: state = PASS, `hold_data` = 0, `writeback_used` = 0, `inst_to_the_next` = 0, `wb_data` = 0, `wb_we` = 0, `wb_rd` = 0.
- Reset mid-HOLD: the held instruction is dropped and no write-back occurs.
- Latency is one cycle. An instruction present in cycle N, with `memory2_stall` = 0, appears on the outputs in N+1.
- Stall starting in cycle N: the `doutb` value from cycle N is captured at the end of N. A stall of any length S gives outputs in cycle N+S+1 carrying cycle-N `doutb`.
- `flush` & `memory2_stall` in the same cycle: `flush` wins. Next cycle `writeback_used` = 0 and `wb_we` = 0.
- ~`memory2_used` with no stall: a bubble. `writeback_used` = 0, `wb_we` = 0, and the FSM stays in PASS.
- Both lanes are loads: both are served from the same `doutb` word. There is no extra latency.

## Test plan
- Reset: hold `rstn` = 0 for 2 cycles with random inputs. Every output must be 0 and the FSM must be in PASS.
- Load/ALU lane mix: lane 0 = LOAD rd=3, lane 1 = ALU rd=4. Drive `doutb` = 64'hAAAA_BBBB_1111_2222 and `alu_result` = 64'h0000_0005_xxxx_xxxx, no stall. Next cycle: `wb_data` = 64'h0000_0005_1111_2222, `wb_we` = 2'b11, `wb_rd` = {4,3}.
- Stall across a load: LOAD in lane 1 with `doutb` = 64'hDEAD_BEEF_0000_0000, stall for 3 cycles, and `doutb` changes to junk after the first cycle. On release: `wb_data[63:32]` = 32'hDEAD_BEEF, and outputs are unchanged during the stall.
- Flush during HOLD: stall 2 cycles, then assert `flush` & `memory2_stall` together. Next cycle `writeback_used` = 0 and `wb_we` = 0. The next load passes with its fresh `doutb`, not the stale `hold_data`.
- rd = 0 and bubbles: a LOAD with rd = 0 gives `wb_we[0]` = 0. `memory2_used` = 0 gives `writeback_used` = 0 the next cycle.
- Reset mid-stall: enter HOLD, then pulse `rstn` = 0. Outputs = 0. After reset the FSM is in PASS and the old `hold_data` never appears on `wb_data`.
